soc_dmem: RTL and testbench

Data-memory responder for the SOC bus: the slave end of the CPU's `vld/rdy` memory handshake, serving the DMEM window at 0x1000_0000–0x1FFF_FFFF, which holds stack and data. It owns a single-port word RAM with byte write strobes and a small handshake FSM. The FSM inserts exactly one wait state per access. An optional per-byte parity check is included.

---
 rtl/soc_dmem_if.sv | 17 +
 rtl/soc_dmem.sv | 113 +++++++++++
 tb/tb_soc_dmem.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/soc_dmem_if.sv
// DMEM slave bus bundle: vld/rdy handshake, byte strobes, read data and parity status.
interface soc_dmem_if;
  logic        vld;
  logic        rdy;
  logic [3:0]  we;
  logic [29:0] addr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        perr_inj;
  logic        perr;
  logic [7:0]  perr_cnt;

  modport master (output vld, we, addr, wdat, perr_inj,
                  input  rdy, rdat, perr, perr_cnt);
  modport slave  (input  vld, we, addr, wdat, perr_inj,
                  output rdy, rdat, perr, perr_cnt);
endinterface

// File: rtl/soc_dmem.sv
// DMEM responder: one-wait-state vld/rdy slave over a byte-laned word RAM.
// Optional per-byte even parity when SOC_DMEM_PARITY_EN is defined.
module soc_dmem #(
  parameter int NUM_WORDS = 8192,
  parameter int AW        = $clog2(NUM_WORDS)
) (
  input  logic      clk,
  input  logic      arst_n,
  soc_dmem_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  logic [0:0]                 state;
  logic                       is_rd;
  logic                       launch;
  logic                       rd_launch;
  logic [AW-1:0]              idx;
  logic [NUM_LANES-1:0][7:0]  rbyte;
  logic [NUM_LANES-1:0]       lane_perr;
  logic                       ack_rd;

  // Upper word-address bits alias onto the decoded window.
  logic unused_addr;
  assign unused_addr = ^bus.addr[29:AW];

  assign idx       = bus.addr[AW-1:0];
  assign launch    = (state == IDLE) && bus.vld;
  assign rd_launch = launch && (bus.we == 4'b0000);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      is_rd <= 1'b0;
    end else if (launch) begin
      state <= ACK;
      is_rd <= (bus.we == 4'b0000);
    end else if (state == ACK) begin
      state <= IDLE;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    soc_dmem_lane #(.NUM_WORDS(NUM_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .wr_en (launch & bus.we[g]),
      .rd_en (rd_launch),
      .idx   (idx),
      .wbyte (bus.wdat[8*g +: 8]),
      .inj   (bus.perr_inj),
      .rbyte (rbyte[g]),
      .perr  (lane_perr[g])
    );
  end

  // Outputs derive only from state flops and the RAM output register.
  assign ack_rd   = (state == ACK) && is_rd;
  assign bus.rdy  = (state == ACK);
  assign bus.rdat = ack_rd ? rbyte : 32'h0;
  assign bus.perr = ack_rd && (|lane_perr);

`ifdef SOC_DMEM_PARITY_EN
  logic [7:0] perr_cnt;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                            perr_cnt <= 8'h00;
    else if (bus.perr && perr_cnt != 8'hFF) perr_cnt <= perr_cnt + 8'h01;
  end
  assign bus.perr_cnt = perr_cnt;
`else
  assign bus.perr_cnt = 8'h00;
`endif
endmodule

// One byte lane of the RAM; with parity each entry carries an even-parity bit.
module soc_dmem_lane #(
  parameter int NUM_WORDS = 8192,
  parameter int AW        = 13
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wbyte,
  input  logic          inj,
  output logic [7:0]    rbyte,
  output logic          perr
);
`ifdef SOC_DMEM_PARITY_EN
  logic [8:0] mem [NUM_WORDS];
  logic [8:0] q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= {(^wbyte) ^ inj, wbyte};
    if (rd_en) q <= mem[idx];
  end

  // Stored bit equals XOR of the data byte, so the 9-bit XOR is zero when clean.
  assign rbyte = q[7:0];
  assign perr  = ^q;
`else
  logic [7:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wbyte;
    if (rd_en) rbyte <= mem[idx];
  end

  logic unused_inj;
  assign unused_inj = inj;
  assign perr       = 1'b0;
`endif
endmodule

// File: tb/tb_soc_dmem.sv
// Scoreboard bench for soc_dmem: stimulus pushes expected acks, negedge monitor checks them.
module tb_soc_dmem;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  soc_dmem_if bus();

  soc_dmem dut (.clk(clk), .arst_n(arst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdat; logic perr; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ack = -100;
  int b2b_pulses = 0;
  bit gap_chk = 1'b0;
  logic prev_rdy = 1'b0;

`ifdef SOC_DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every ack pops one expectation; idle cycles must show zero read data.
  always @(negedge clk) begin
    if (!arst_n) begin
      prev_rdy = 1'b0;
    end else begin
      if (bus.rdy) begin
        check("no_double_ack", {31'b0, prev_rdy}, 32'd0);
        if (gap_chk) begin
          b2b_pulses++;
          if (b2b_pulses > 1) check("b2b_gap", cyc - last_ack, 32'd2);
        end
        last_ack = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdat", bus.rdat, e.rdat);
          check("perr", {31'b0, bus.perr}, {31'b0, e.perr});
        end
      end else begin
        check("idle_rdat", bus.rdat, 32'd0);
      end
      prev_rdy = bus.rdy;
    end
  end

  // Issues one transfer and returns #1 after the ack edge; vld stays high.
  task automatic xfer(input logic [3:0] we, input logic [31:0] baddr,
                      input logic [31:0] wdat, input logic inj,
                      input logic [31:0] exp_rdat, input logic exp_perr);
    exp_t e;
    bit seen = 1'b0;
    bus.vld = 1'b1; bus.we = we; bus.addr = baddr[31:2];
    bus.wdat = wdat; bus.perr_inj = inj;
    e.rdat = exp_rdat; e.perr = exp_perr;
    exp_q.push_back(e);
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.rdy) seen = 1'b1;
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.vld = 1'b0; bus.we = 4'h0; bus.perr_inj = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d;
    bus.vld = 1'b0; bus.we = 4'h0; bus.addr = '0; bus.wdat = '0; bus.perr_inj = 1'b0;
    #12;
    check("rst_rdy", {31'b0, bus.rdy}, 32'd0);
    check("rst_rdat", bus.rdat, 32'd0);
    check("rst_perr", {31'b0, bus.perr}, 32'd0);
    check("rst_cnt", {24'b0, bus.perr_cnt}, 32'd0);
    @(posedge clk); #1 arst_n = 1'b1;
    @(posedge clk); #1;

    // Full write / read, then partial-strobe merge.
    xfer(4'hF, 32'h1000_0010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0); idle();
    xfer(4'h0, 32'h1000_0010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0); idle();
    xfer(4'b0101, 32'h1000_0010, 32'h11223344, 1'b0, 32'h0, 1'b0); idle();
    xfer(4'h0, 32'h1000_0010, 32'h0, 1'b0, 32'hDE22BE44, 1'b0); idle();

    // Aliasing: 0x1000_8004 folds onto word 1.
    xfer(4'hF, 32'h1000_0004, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0); idle();
    xfer(4'h0, 32'h1000_8004, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0); idle();

    // Back-to-back with vld held throughout.
    gap_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = 32'hC0DE_0000 ^ (32'h0101_0101 * i);
      xfer(4'hF, 32'h1000_0100 + 32'(i * 4), d, 1'b0, 32'h0, 1'b0);
      xfer(4'h0, 32'h1000_0100 + 32'(i * 4), 32'h0, 1'b0, d, 1'b0);
    end
    idle();
    gap_chk = 1'b0;
    check("b2b_pulses", b2b_pulses, 32'd32);

    // Reset during the ACK of a read: never acknowledged, then reissued.
    bus.vld = 1'b1; bus.we = 4'h0; bus.addr = 30'h0400_0004; bus.perr_inj = 1'b0;
    @(posedge clk); #1;
    check("ack_before_rst", {31'b0, bus.rdy}, 32'd1);
    arst_n = 1'b0; bus.vld = 1'b0;
    #1;
    check("rst_ack_rdy", {31'b0, bus.rdy}, 32'd0);
    check("rst_ack_rdat", bus.rdat, 32'd0);
    @(posedge clk); #1 arst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {31'b0, bus.rdy}, 32'd0);
    xfer(4'h0, 32'h1000_0010, 32'h0, 1'b0, 32'hDE22BE44, 1'b0); idle();

    // Parity injection and recovery.
    xfer(4'hF, 32'h1000_0020, 32'h12345678, 1'b1, 32'h0, 1'b0); idle();
    for (int i = 0; i < 3; i++) begin
      xfer(4'h0, 32'h1000_0020, 32'h0, 1'b0, 32'h12345678, PAR); idle();
    end
    check("perr_cnt_3", {24'b0, bus.perr_cnt}, PAR ? 32'd3 : 32'd0);
    xfer(4'hF, 32'h1000_0020, 32'h12345678, 1'b0, 32'h0, 1'b0); idle();
    xfer(4'h0, 32'h1000_0020, 32'h0, 1'b0, 32'h12345678, 1'b0); idle();
    check("perr_cnt_hold", {24'b0, bus.perr_cnt}, PAR ? 32'd3 : 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
